// File: rtl/lattice_sequencer.sv
// Lattice pattern scheduler: auto-advance with blank gaps, manual step/pause, 7-seg status word.
// One-tick latency: every output is registered; there is no backpressure, inputs are sampled each tick.
module lattice_sequencer #(
    parameter int NUM_PATTERNS = 5,
    parameter int DWELL        = 4,
    parameter int GAP          = 1
) (
    input  logic        clk_2,
    input  logic        rst,
    input  logic        enable,
    input  logic        pause,
    input  logic        step_next,
    input  logic        step_prev,
    input  logic        dir,
    output logic [3:0]  code,
    output logic        blank,
    output logic [23:0] seg_code,
    output logic        frame_start
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP_ST = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX   = 4'(NUM_PATTERNS - 1);
    localparam logic [7:0] DWELL_LOAD = 8'(DWELL - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP - 1);
    localparam bit         HAS_GAP    = (GAP > 0);

    state_t      state_q, state_d;
    logic [3:0]  code_d;
    logic [7:0]  dwell_q, dwell_d;
    logic [7:0]  gap_q, gap_d;
    logic        fs_d;
    logic        blank_d;
    logic [23:0] seg_d;

    logic        step_one;
    logic [3:0]  idx_inc, idx_dec, step_code, auto_code;
    logic [3:0]  dwell_sat;

    always_comb begin
        idx_inc   = (code == LAST_IDX) ? 4'd0 : code + 4'd1;
        idx_dec   = (code == 4'd0) ? LAST_IDX : code - 4'd1;
        // Simultaneous next/prev cancel out and fall through to the normal rules.
        step_one  = step_next ^ step_prev;
        step_code = step_next ? idx_inc : idx_dec;
        auto_code = dir ? idx_dec : idx_inc;
    end

    always_comb begin
        state_d = state_q;
        code_d  = code;
        dwell_d = dwell_q;
        gap_d   = gap_q;
        fs_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = SHOW;
                    code_d  = dir ? LAST_IDX : 4'd0;
                    dwell_d = DWELL_LOAD;
                    fs_d    = 1'b1;
                end
            end
            SHOW: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (step_one) begin
                    code_d  = step_code;
                    dwell_d = DWELL_LOAD;
                    fs_d    = 1'b1;
                end else if (pause) begin
                    state_d = HOLD;
                end else if (dwell_q == 8'd0 && !HAS_GAP) begin
                    code_d  = auto_code;
                    dwell_d = DWELL_LOAD;
                    fs_d    = 1'b1;
                end else if (dwell_q == 8'd0) begin
                    state_d = GAP_ST;
                    gap_d   = GAP_LOAD;
                end else begin
                    dwell_d = dwell_q - 8'd1;
                end
            end
            GAP_ST: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (step_one) begin
                    state_d = SHOW;
                    code_d  = step_code;
                    dwell_d = DWELL_LOAD;
                    fs_d    = 1'b1;
                end else if (pause) begin
                    state_d = GAP_ST;
                end else if (gap_q == 8'd0) begin
                    state_d = SHOW;
                    code_d  = auto_code;
                    dwell_d = DWELL_LOAD;
                    fs_d    = 1'b1;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            HOLD: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (step_one) begin
                    code_d  = step_code;
                    dwell_d = DWELL_LOAD;
                    fs_d    = 1'b1;
                end else if (!pause) begin
                    state_d = SHOW;
                end
            end
            default: state_d = IDLE;
        endcase

        blank_d   = (state_d == IDLE) || (state_d == GAP_ST);
        dwell_sat = (dwell_d > 8'd15) ? 4'hF : dwell_d[3:0];
        seg_d     = {12'hFFF, 2'b00, state_d, dwell_sat, code_d};
    end

    always_ff @(posedge clk_2 or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            code        <= 4'd0;
            blank       <= 1'b1;
            frame_start <= 1'b0;
            dwell_q     <= 8'd0;
            gap_q       <= 8'd0;
            seg_code    <= 24'hFFF000;
        end else begin
            state_q     <= state_d;
            code        <= code_d;
            blank       <= blank_d;
            frame_start <= fs_d;
            dwell_q     <= dwell_d;
            gap_q       <= gap_d;
            seg_code    <= seg_d;
        end
    end

endmodule

// File: tb/tb_lattice_sequencer.sv
// Scoreboard bench for lattice_sequencer with default parameters (5 patterns, dwell 4, gap 1).
module tb_lattice_sequencer;

    localparam int NP = 5;
    localparam int DW = 4;
    localparam int GP = 1;

    logic        clk_2 = 1'b0;
    logic        rst;
    logic        enable, pause, step_next, step_prev, dir;
    logic [3:0]  code;
    logic        blank;
    logic [23:0] seg_code;
    logic        frame_start;

    lattice_sequencer #(.NUM_PATTERNS(NP), .DWELL(DW), .GAP(GP)) dut (
        .clk_2      (clk_2),
        .rst        (rst),
        .enable     (enable),
        .pause      (pause),
        .step_next  (step_next),
        .step_prev  (step_prev),
        .dir        (dir),
        .code       (code),
        .blank      (blank),
        .seg_code   (seg_code),
        .frame_start(frame_start)
    );

    always #5 clk_2 = ~clk_2;

    typedef struct {
        logic [3:0]  code;
        logic        blank;
        logic        fs;
        logic [23:0] seg;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    // Reference model state: 0 idle, 1 show, 2 gap, 3 hold
    int         m_state;
    int         m_code;
    int         m_dwell;
    int         m_gap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_code = 0; m_dwell = 0; m_gap = 0;
    endtask

    task automatic model_step(output exp_t e);
        bit single;
        int stepped, autoc, show_dw;
        e.fs    = 1'b0;
        single  = (step_next != step_prev);
        stepped = step_next ? (m_code + 1) % NP : (m_code + NP - 1) % NP;
        autoc   = dir ? (m_code + NP - 1) % NP : (m_code + 1) % NP;
        case (m_state)
            0: if (enable) begin
                m_state = 1; m_code = dir ? NP - 1 : 0; m_dwell = DW - 1; e.fs = 1'b1;
            end
            1: if (!enable) m_state = 0;
               else if (single) begin m_code = stepped; m_dwell = DW - 1; e.fs = 1'b1; end
               else if (pause) m_state = 3;
               else if (m_dwell == 0 && GP == 0) begin m_code = autoc; m_dwell = DW - 1; e.fs = 1'b1; end
               else if (m_dwell == 0) begin m_state = 2; m_gap = GP - 1; end
               else m_dwell--;
            2: if (!enable) m_state = 0;
               else if (single) begin m_state = 1; m_code = stepped; m_dwell = DW - 1; e.fs = 1'b1; end
               else if (pause) m_state = 2;
               else if (m_gap == 0) begin m_state = 1; m_code = autoc; m_dwell = DW - 1; e.fs = 1'b1; end
               else m_gap--;
            default: if (!enable) m_state = 0;
               else if (single) begin m_code = stepped; m_dwell = DW - 1; e.fs = 1'b1; end
               else if (!pause) m_state = 1;
        endcase
        show_dw = (m_dwell > 15) ? 15 : m_dwell;
        e.code  = m_code[3:0];
        e.blank = (m_state == 0 || m_state == 2);
        e.seg   = {12'hFFF, 4'(m_state), 4'(show_dw), 4'(m_code)};
    endtask

    task automatic tick();
        exp_t e;
        model_step(e);
        sb.push_back(e);
        @(posedge clk_2);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("code", 32'(code), 32'(e.code));
            chk("blank", 32'(blank), 32'(e.blank));
            chk("frame_start", 32'(frame_start), 32'(e.fs));
            chk("seg_code", 32'(seg_code), 32'(e.seg));
        end
    endtask

    task automatic pulse(input bit nxt, input bit prv);
        step_next = nxt; step_prev = prv;
        tick();
        step_next = 1'b0; step_prev = 1'b0;
    endtask

    logic [3:0] fs_codes[$];
    logic [3:0] exp_fwd[6];
    logic [3:0] exp_rev[6];

    initial begin
        exp_fwd = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        exp_rev = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd4};
        rst = 1'b1; enable = 1'b0; pause = 1'b0; step_next = 1'b0; step_prev = 1'b0; dir = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_2);
        #1;
        chk("rst_code", 32'(code), 32'd0);
        chk("rst_blank", 32'(blank), 32'd1);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_seg", 32'(seg_code), 32'hFFF000);
        rst = 1'b0;

        // Forward auto-advance over a full 25-tick cycle plus one
        enable = 1'b1; dir = 1'b0;
        for (int i = 0; i < 26; i++) begin
            tick();
            if (frame_start) fs_codes.push_back(code);
        end
        chk("fwd_frames", 32'(fs_codes.size()), 32'd6);
        for (int i = 0; i < 6 && i < fs_codes.size(); i++) chk("fwd_seq", 32'(fs_codes[i]), 32'(exp_fwd[i]));

        // Reverse from IDLE
        enable = 1'b0; tick();
        chk("idle_state", 32'(seg_code[11:8]), 32'd0);
        fs_codes.delete();
        dir = 1'b1; enable = 1'b1;
        for (int i = 0; i < 26; i++) begin
            tick();
            if (frame_start) fs_codes.push_back(code);
        end
        chk("rev_frames", 32'(fs_codes.size()), 32'd6);
        for (int i = 0; i < 6 && i < fs_codes.size(); i++) chk("rev_seq", 32'(fs_codes[i]), 32'(exp_rev[i]));

        // Pause at code 2 with two dwell ticks remaining
        enable = 1'b0; dir = 1'b0; tick();
        enable = 1'b1;
        repeat (12) tick();
        chk("pre_pause_code", 32'(code), 32'd2);
        chk("pre_pause_dwell", 32'(seg_code[7:4]), 32'd2);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_state", 32'(seg_code[11:8]), 32'd3);
            chk("hold_dwell", 32'(seg_code[7:4]), 32'd2);
        end
        pause = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("resume_code", 32'(code), 32'd2);
            chk("resume_blank", 32'(blank), 32'd0);
        end
        tick();
        chk("resume_gap", 32'(blank), 32'd1);
        tick();
        chk("after_gap_code", 32'(code), 32'd3);
        chk("after_gap_fs", 32'(frame_start), 32'd1);

        // Manual steps with wrap in both directions, then a cancelled pair
        pulse(1'b1, 1'b0);
        chk("step_to4", 32'(code), 32'd4);
        pulse(1'b1, 1'b0);
        chk("wrap_next", 32'(code), 32'd0);
        chk("wrap_next_fs", 32'(frame_start), 32'd1);
        chk("wrap_next_blank", 32'(blank), 32'd0);
        chk("wrap_next_dwell", 32'(seg_code[7:4]), 32'd3);
        pulse(1'b0, 1'b1);
        chk("wrap_prev", 32'(code), 32'd4);
        pulse(1'b1, 1'b1);
        chk("both_code", 32'(code), 32'd4);
        chk("both_fs", 32'(frame_start), 32'd0);

        // Step out of a gap
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        chk("at_code1", 32'(code), 32'd1);
        repeat (4) tick();
        chk("gap_state", 32'(seg_code[11:8]), 32'd2);
        chk("gap_blank", 32'(blank), 32'd1);
        pulse(1'b1, 1'b0);
        chk("gap_step_code", 32'(code), 32'd2);
        chk("gap_step_blank", 32'(blank), 32'd0);
        chk("gap_step_fs", 32'(frame_start), 32'd1);

        // Asynchronous reset during a gap, between clock edges
        repeat (4) tick();
        chk("gap2_blank", 32'(blank), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_code", 32'(code), 32'd0);
        chk("arst_blank", 32'(blank), 32'd1);
        chk("arst_fs", 32'(frame_start), 32'd0);
        chk("arst_seg", 32'(seg_code), 32'hFFF000);
        model_reset();
        rst = 1'b0;
        tick();
        chk("restart_code", 32'(code), 32'd0);
        chk("restart_blank", 32'(blank), 32'd0);
        enable = 1'b0;
        tick();
        chk("disable_blank", 32'(blank), 32'd1);
        chk("disable_state", 32'(seg_code[11:8]), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
